// File: rtl/uart_tx_lockq.sv
// uart_tx_lockq -- 8N1/8N2 UART transmitter gated by a qualified PLL lock.
//
// Serialises bytes accepted over a valid/ready handshake onto an idle-high TX
// line, LSB first. Transmission is only permitted after the synchronised PLL
// lock flag has been held for LOCK_HOLD consecutive cycles. Losing lock
// aborts any frame in progress and forces full requalification.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit(s).
//
// Ports:
//   clk          60 MHz clock from the PLL output
//   rst_n        asynchronous active-low reset
//   pll_locked   PLL lock flag, asynchronous to clk
//   tx_data      byte to send, held stable while tx_valid=1 and tx_ready=0
//   tx_valid     byte available
//   tx_ready     block can accept a byte this cycle
//   tx           serial line, idle high, driven from a flop
//   busy         frame in progress (START..STOP)
//   tx_enabled   lock qualified, TX permitted
//   frame_abort  one-cycle pulse when a frame is cut short by lock loss
module uart_tx_lockq #(
    parameter int unsigned CLKS_PER_BIT = 5,
    parameter int unsigned LOCK_HOLD    = 256,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_enabled,
    output logic       frame_abort
);

    localparam int unsigned BCW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int unsigned LCW = $clog2(LOCK_HOLD + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_HOLD);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {WAIT_LOCK, IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {WAIT_LOCK, IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic             lock_m, lock_s;
    logic [LCW-1:0]   lock_cnt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             tx_n, busy_n, abort_n;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit, parity_n;
`endif

    // lock_s gates tx_ready so a handshake can never coincide with the cycle
    // in which lock loss forces the FSM back to WAIT_LOCK.
    assign tx_ready = (state == IDLE) && tx_enabled && lock_s;

    // Lock synchroniser and qualification counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            lock_cnt   <= '0;
            tx_enabled <= 1'b0;
        end else begin
            lock_m     <= pll_locked;
            lock_s     <= lock_m;
            if (!lock_s)
                lock_cnt <= '0;
            else if (lock_cnt != LOCK_MAX)
                lock_cnt <= lock_cnt + 1'b1;
            tx_enabled <= lock_s && (lock_cnt == LOCK_MAX);
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = '0;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        abort_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n  = parity_bit;
`endif
        if (state != WAIT_LOCK && !lock_s) begin
            state_n = WAIT_LOCK;
            abort_n = (state != IDLE);
        end else begin
            case (state)
                WAIT_LOCK: if (tx_enabled && lock_s) state_n = IDLE;
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state_n  = START;
                        shreg_n  = tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_n = ^tx_data;
`endif
                    end
                end
                START: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                    end
                end
                DATA: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            // Next bit within DATA: the state does not change,
                            // so the bit timer is restarted explicitly here.
                            bit_idx_n = bit_idx + 1'b1;
                            shreg_n   = shreg >> 1;
                            bit_cnt_n = '0;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                end
`endif
                STOP: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == STOP_LAST) state_n = IDLE;
                end
                default: state_n = WAIT_LOCK;
            endcase
        end
        if (state_n != state) bit_cnt_n = '0;

        // Registered outputs are derived from the next state so that tx and
        // busy change on the same edge as the state register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = parity_n;
`endif
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != WAIT_LOCK) && (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LOCK;
            bit_cnt     <= '0;
            bit_idx     <= 3'd0;
            shreg       <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            tx          <= tx_n;
            busy        <= busy_n;
            frame_abort <= abort_n;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= parity_n;
`endif
        end
    end

endmodule

// File: doc/uart_tx_lockq.md
Name: uart_tx_lockq

Overview:
8N1 UART transmitter running in the 60 MHz PLL output domain, sending at 12 Mbps (5 clocks/bit).
- Sits directly downstream of the PLL: clocked by the PLL output clock and qualified by the PLL locked signal.
- Accepts bytes over a valid/ready handshake and serialises them onto the TX line towards the Raspberry Pi.
- Refuses and aborts traffic whenever lock is not held stable.

Parameters:
CLKS_PER_BIT, 5, clock cycles per UART bit (60 MHz / 12 Mbps); legal range 2..65535.
LOCK_HOLD, 256, consecutive cycles of synchronised lock required before TX is enabled; legal range 1..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  60 MHz clock from PLL output.
rst_n  input  1  asynchronous active-low reset.
pll_locked  input  1  PLL lock flag; asynchronous to clk.
tx_data  input  8  byte to send; must be held stable while tx_valid=1 and tx_ready=0.
tx_valid  input  1  byte available.
tx_ready  output  1  block can accept a byte this cycle.
tx  output  1  serial line; idle high.
busy  output  1  frame in progress (START..STOP).
tx_enabled  output  1  lock qualified; TX permitted.
frame_abort  output  1  one-cycle pulse when a frame is cut short by lock loss.

Behaviour:
- Reset (rst_n=0, async): tx=1, tx_ready=0, busy=0, tx_enabled=0, frame_abort=0, state=WAIT_LOCK, all counters 0.
- Lock sync: pll_locked passes through a 2-FF synchroniser (lock_s).
- Lock counter: counts while lock_s=1 and saturates at LOCK_HOLD; clears to 0 the cycle after lock_s=0.
  - tx_enabled=1 iff counter==LOCK_HOLD, registered.
- States: WAIT_LOCK, IDLE, START, DATA, [PARITY], STOP.
- WAIT_LOCK: tx=1. Moves to IDLE the cycle after tx_enabled=1.
- IDLE: tx=1, tx_ready=1 (combinational from state and tx_enabled). Handshake = tx_valid & tx_ready.
  - On handshake: latch tx_data into the shift register and go to START.
  - tx falls on the next clock edge, so latency is 1 cycle.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Bit index 0..7; after bit 7, go to PARITY if enabled, else STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
  - Exactly one IDLE cycle with tx_ready=1 separates back-to-back frames.
  - Frame period = 1 + (10 + STOP_BITS - 1 [+1 parity]) * CLKS_PER_BIT cycles.
- busy=1 in START/DATA/PARITY/STOP.
- tx_ready=0 in every state except IDLE. tx_valid outside IDLE is ignored; the byte is not consumed.
- Lock loss (lock_s=0):
  - In IDLE/START/DATA/PARITY/STOP: next cycle state=WAIT_LOCK, tx=1, busy=0, tx_ready=0, tx_enabled=0.
  - frame_abort pulses 1 cycle only if busy was 1. The aborted byte is dropped, not retried.
  - Lock loss has priority over a simultaneous handshake: the byte is not accepted.
- Bit-time counter width: $clog2(STOP_BITS*CLKS_PER_BIT+1). It reloads to 0 on every state change and on reset.
- Re-lock: a full LOCK_HOLD requalification is required before returning to IDLE.
- tx is driven from a flop (glitch-free). All outputs except tx_ready are registered.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted after DATA. tx = XOR of the 8 data bits (even parity), held CLKS_PER_BIT cycles. Frame is 11 bits + extra stop bits.
- Undefined: no PARITY state and no parity logic; plain 8N1 (or 8N2).

Test Plan:
1. Reset, then pll_locked=1 from cycle 0, with LOCK_HOLD=256 → tx=1 and tx_ready=0 throughout; tx_enabled rises at cycle 256+2 sync+1; tx_ready=1 the cycle after.
2. Send 0xA5 with defaults → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 5 cycles; tx low the cycle after handshake; busy high 50 cycles.
3. tx_valid held high with 0x00 then 0xFF → two frames separated by exactly 1 idle cycle; tx_ready pulses once per frame; period 51 cycles.
4. Drop pll_locked during DATA bit 3 → within 3 cycles tx=1, frame_abort pulses once, tx_ready=0. Re-raise lock → tx_ready returns only after a full LOCK_HOLD.
5. Pulse pll_locked low for 1 cycle while in IDLE with tx_valid=1 → no handshake; counter restarts; no frame_abort (busy=0).
6. Define UART_TX_PARITY_EN, send 0x07 → parity bit 1 after data; frame 55 cycles; send 0x03 → parity bit 0.
